// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
// Register fields are held at MAX_AW bits; narrower addresses are zero-extended.
package hazard_pkg;

    localparam int MAX_AW = 8;

    typedef logic [MAX_AW-1:0] reg_t;

    typedef struct packed {
        logic v;
        reg_t rd;
        logic regwrite;
        logic memread;
        reg_t rs1;
        reg_t rs2;
        logic rs1_used;
        logic rs2_used;
    } stage_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;

endpackage

// File: rtl/hazard_match.sv
// Single RAW comparator: does a tracked writer produce the register a source reads.
// XZR never matches since writes to it are discarded.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int ZERO_REG = 31
) (
    input  logic              v,
    input  logic              regwrite,
    input  logic [MAX_AW-1:0] rd,
    input  logic [MAX_AW-1:0] rs,
    input  logic              used,
    output logic              hit
);

    localparam logic [MAX_AW-1:0] ZR = MAX_AW'(ZERO_REG);

    assign hit = v & regwrite & used & (rs == rd) & (rs != ZR);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall, branch-kill and forwarding-select control for the 5-stage LEGv8 core.
// Outputs are combinational from the EX/MEM/WB tracker and the ID/branch inputs.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int FWD_EN   = 1,
    parameter int BR_STAGE = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                br_taken,
    output logic                stall,
    output logic [BR_STAGE-1:0] kill,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    stage_t id_s;
    stage_t e_q;
    stage_t m_q;
    stage_t w_q;

    logic hit_ea, hit_eb;
    logic hit_ma, hit_mb;
    logic hit_wa, hit_wb;
    logic raw_stall;
    reg_t m_rs1, m_rs2;
    logic m_u1, m_u2;

    assign id_s = '{
        v:        id_valid,
        rd:       reg_t'(id_rd),
        regwrite: id_regwrite,
        memread:  id_memread,
        rs1:      reg_t'(id_rs1),
        rs2:      reg_t'(id_rs2),
        rs1_used: id_rs1_used,
        rs2_used: id_rs2_used
    };

    // MEM comparators serve EX forwarding, or ID stalling when forwarding is off.
    assign m_rs1 = (FWD_EN != 0) ? e_q.rs1 : id_s.rs1;
    assign m_rs2 = (FWD_EN != 0) ? e_q.rs2 : id_s.rs2;
    assign m_u1  = (FWD_EN != 0) ? e_q.rs1_used : id_s.rs1_used;
    assign m_u2  = (FWD_EN != 0) ? e_q.rs2_used : id_s.rs2_used;

    hazard_match #(.ZERO_REG(ZERO_REG)) u_ea (
        .v(e_q.v), .regwrite(e_q.regwrite), .rd(e_q.rd),
        .rs(id_s.rs1), .used(id_s.rs1_used), .hit(hit_ea)
    );
    hazard_match #(.ZERO_REG(ZERO_REG)) u_eb (
        .v(e_q.v), .regwrite(e_q.regwrite), .rd(e_q.rd),
        .rs(id_s.rs2), .used(id_s.rs2_used), .hit(hit_eb)
    );
    hazard_match #(.ZERO_REG(ZERO_REG)) u_ma (
        .v(m_q.v), .regwrite(m_q.regwrite), .rd(m_q.rd),
        .rs(m_rs1), .used(m_u1), .hit(hit_ma)
    );
    hazard_match #(.ZERO_REG(ZERO_REG)) u_mb (
        .v(m_q.v), .regwrite(m_q.regwrite), .rd(m_q.rd),
        .rs(m_rs2), .used(m_u2), .hit(hit_mb)
    );
    hazard_match #(.ZERO_REG(ZERO_REG)) u_wa (
        .v(w_q.v), .regwrite(w_q.regwrite), .rd(w_q.rd),
        .rs(e_q.rs1), .used(e_q.rs1_used), .hit(hit_wa)
    );
    hazard_match #(.ZERO_REG(ZERO_REG)) u_wb (
        .v(w_q.v), .regwrite(w_q.regwrite), .rd(w_q.rd),
        .rs(e_q.rs2), .used(e_q.rs2_used), .hit(hit_wb)
    );

    always_comb begin
        if (FWD_EN != 0)
            raw_stall = id_valid & e_q.memread & (hit_ea | hit_eb);
        else
            raw_stall = id_valid & (hit_ea | hit_eb | hit_ma | hit_mb);
    end

    // A taken branch kills the stalled ID instruction, so the stall is moot.
    assign stall = raw_stall & ~br_taken;

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN != 0 && e_q.v) begin
            if (hit_ma)      fwd_a = FWD_EXMEM;
            else if (hit_wa) fwd_a = FWD_MEMWB;
            if (hit_mb)      fwd_b = FWD_EXMEM;
            else if (hit_wb) fwd_b = FWD_MEMWB;
        end
    end

    assign kill[IFID] = br_taken;
    assign kill[IDEX] = br_taken;

    if (BR_STAGE > EXMEM) begin : g_kill_exmem
        assign kill[EXMEM] = br_taken;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            e_q   <= id_s;
            e_q.v <= id_valid & ~stall & ~br_taken;
            m_q   <= e_q;
            if (BR_STAGE == 3 && br_taken)
                m_q.v <= 1'b0;
            w_q   <= m_q;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (br_taken && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{w_q.memread, w_q.rs1, w_q.rs2,
                           w_q.rs1_used, w_q.rs2_used,
                           m_q.memread, m_q.rs1, m_q.rs2,
                           m_q.rs1_used, m_q.rs2_used,
                           hit_wa, hit_wb, hit_ma, hit_mb,
                           e_q.memread};

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three configurations driven in parallel and
// compared each cycle against a pipeline-list model, plus directed tables.
module tb_hazard_ctrl_unit;

    typedef struct {
        bit v;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    typedef struct {
        bit   rst;
        bit   br;
        ins_t i;
    } in_t;

    typedef struct {
        in_t in;
        int  st;
        int  kl;
        int  fa;
        int  fb;
        int  sc;
        int  fc;
    } vec_t;

    // configurations: 0 = forwarding/MEM branch, 1 = no forwarding, 2 = EX branch, 3-bit counters
    int FE[3]   = '{1, 0, 1};
    int BS[3]   = '{3, 3, 2};
    int CMAX[3] = '{65535, 65535, 7};

    logic clock = 1'b0;
    logic reset;
    logic id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, br_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        st0, st1, st2;
    logic [2:0]  kl0, kl1;
    logic [1:0]  kl2;
    logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [2:0]  sc2, fc2;

    always #5 clock = ~clock;

    hazard_ctrl_unit #(.FWD_EN(1), .BR_STAGE(3), .CNT_W(16)) u_dut0 (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .br_taken(br_taken), .stall(st0), .kill(kl0),
        .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_ctrl_unit #(.FWD_EN(0), .BR_STAGE(3), .CNT_W(16)) u_dut1 (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .br_taken(br_taken), .stall(st1), .kill(kl1),
        .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_ctrl_unit #(.FWD_EN(1), .BR_STAGE(2), .CNT_W(3)) u_dut2 (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .br_taken(br_taken), .stall(st2), .kill(kl2),
        .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(sc2), .flush_cnt(fc2)
    );

    int   nerr = 0;
    int   nchk = 0;
    in_t  cur;
    ins_t pipe[3][3];   // per config: [0] = in EX, [1] = in MEM, [2] = in WB
    int   msc[3];
    int   mfc[3];
    bit   es[3];
    vec_t tbl[$];

    function automatic ins_t ins(bit v, int rs1, int rs2, bit u1, bit u2,
                                 int rd, bit rw, bit mr);
        ins_t x;
        x.v = v; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2;
        x.rd = rd; x.rw = rw; x.mr = mr;
        return x;
    endfunction

    function automatic in_t mk(bit rst, bit br, ins_t i);
        in_t x;
        x.rst = rst; x.br = br; x.i = i;
        return x;
    endfunction

    task automatic chk(string nm, int k, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s cfg%0d: got %0d expected %0d", nm, k, act, exp);
        end
    endtask

    function automatic bit hit(ins_t p, int rs, bit u);
        return p.v && p.rw && u && (rs == p.rd) && (rs != 31);
    endfunction

    function automatic bit exp_raw(int k);
        bit r = 0;
        int depth = (FE[k] != 0) ? 1 : 2;
        for (int a = 0; a < depth; a++)
            if (hit(pipe[k][a], cur.i.rs1, cur.i.u1) ||
                hit(pipe[k][a], cur.i.rs2, cur.i.u2))
                r = (FE[k] != 0) ? pipe[k][a].mr : 1'b1;
        return cur.i.v && r;
    endfunction

    // newest producer older than the EX instruction supplies the operand
    function automatic int exp_fwd(int k, int rs, bit u);
        if (FE[k] == 0 || !pipe[k][0].v) return 0;
        for (int age = 1; age <= 2; age++)
            if (hit(pipe[k][age], rs, u)) return (age == 1) ? 2 : 1;
        return 0;
    endfunction

    task automatic getact(int k, output int st, output int kl, output int fa,
                          output int fb, output int sc, output int fc);
        case (k)
            0: begin st = int'(st0); kl = int'(kl0); fa = int'(fa0);
                     fb = int'(fb0); sc = int'(sc0); fc = int'(fc0); end
            1: begin st = int'(st1); kl = int'(kl1); fa = int'(fa1);
                     fb = int'(fb1); sc = int'(sc1); fc = int'(fc1); end
            default: begin st = int'(st2); kl = int'(kl2); fa = int'(fa2);
                     fb = int'(fb2); sc = int'(sc2); fc = int'(fc2); end
        endcase
    endtask

    task automatic apply(in_t x);
        int st, kl, fa, fb, sc, fc;
        cur         = x;
        reset       = x.rst;
        br_taken    = x.br;
        id_valid    = x.i.v;
        id_rs1      = 5'(x.i.rs1);
        id_rs2      = 5'(x.i.rs2);
        id_rs1_used = x.i.u1;
        id_rs2_used = x.i.u2;
        id_rd       = 5'(x.i.rd);
        id_regwrite = x.i.rw;
        id_memread  = x.i.mr;
        #1;
        for (int k = 0; k < 3; k++) begin
            es[k] = exp_raw(k) && !x.br;
            getact(k, st, kl, fa, fb, sc, fc);
            chk("stall", k, st, int'(es[k]));
            chk("kill", k, kl, x.br ? ((1 << BS[k]) - 1) : 0);
            chk("fwd_a", k, fa, exp_fwd(k, pipe[k][0].rs1, pipe[k][0].u1));
            chk("fwd_b", k, fb, exp_fwd(k, pipe[k][0].rs2, pipe[k][0].u2));
            chk("stall_cnt", k, sc, msc[k]);
            chk("flush_cnt", k, fc, mfc[k]);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 3; a++) pipe[k][a] = ins(0, 0, 0, 0, 0, 0, 0, 0);
            msc[k] = 0;
            mfc[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (cur.rst) begin
            clear_model();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (es[k] && msc[k] < CMAX[k]) msc[k]++;
                if (cur.br && mfc[k] < CMAX[k]) mfc[k]++;
                pipe[k][2] = pipe[k][1];
                pipe[k][1] = pipe[k][0];
                if (BS[k] == 3 && cur.br) pipe[k][1].v = 0;
                pipe[k][0]   = cur.i;
                pipe[k][0].v = cur.i.v && !es[k] && !cur.br;
            end
        end
        #1;
    endtask

    function automatic int rreg();
        int r = $urandom_range(0, 5);
        if (r == 4) return 31;
        if (r == 5) return $urandom_range(0, 31);
        return r + 1;
    endfunction

    initial begin
        ins_t nop, ld1, a213, orr, ldl;
        int st, kl, fa, fb, sc, fc;
        nop  = ins(0, 0, 0, 0, 0, 0, 0, 0);
        ld1  = ins(1, 9, 0, 1, 0, 1, 1, 1);
        a213 = ins(1, 1, 3, 1, 1, 2, 1, 0);

        reset = 1'b1;
        br_taken = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_regwrite = 0; id_memread = 0;
        cur = mk(1, 0, nop);
        repeat (2) @(posedge clock);
        #1;
        clear_model();

        // expectations for cfg0 (forwarding, MEM-stage branch)
        tbl.push_back('{mk(0, 0, nop),  0, 0, 0, 0, 0, 0});
        tbl.push_back('{mk(0, 0, ld1),  0, 0, 0, 0, 0, 0});
        tbl.push_back('{mk(0, 0, a213), 1, 0, 0, 0, 0, 0});
        tbl.push_back('{mk(0, 0, a213), 0, 0, 0, 0, 1, 0});
        tbl.push_back('{mk(0, 0, nop),  0, 0, 1, 0, 1, 0});
        tbl.push_back('{mk(0, 0, ins(1, 5, 6, 1, 1, 1, 1, 0)),   0, 0, 0, 0, 1, 0});
        tbl.push_back('{mk(0, 0, ins(1, 1, 1, 1, 1, 4, 1, 0)),   0, 0, 0, 0, 1, 0});
        tbl.push_back('{mk(0, 0, nop),  0, 0, 2, 2, 1, 0});
        tbl.push_back('{mk(0, 0, ins(1, 5, 0, 1, 0, 31, 1, 1)),  0, 0, 0, 0, 1, 0});
        tbl.push_back('{mk(0, 0, ins(1, 31, 31, 1, 1, 7, 1, 0)), 0, 0, 0, 0, 1, 0});
        tbl.push_back('{mk(0, 0, nop),  0, 0, 0, 0, 1, 0});
        tbl.push_back('{mk(0, 0, ins(1, 9, 0, 1, 0, 3, 1, 1)),   0, 0, 0, 0, 1, 0});
        tbl.push_back('{mk(0, 1, ins(1, 3, 3, 1, 1, 4, 1, 0)),   0, 7, 0, 0, 1, 0});
        tbl.push_back('{mk(0, 0, ins(1, 3, 0, 1, 1, 5, 1, 0)),   0, 0, 0, 0, 1, 1});
        tbl.push_back('{mk(0, 0, nop),  0, 0, 0, 0, 1, 1});
        tbl.push_back('{mk(0, 0, ld1),  0, 0, 0, 0, 1, 1});
        tbl.push_back('{mk(1, 0, a213), 1, 0, 0, 0, 1, 1});
        tbl.push_back('{mk(0, 0, a213), 0, 0, 0, 0, 0, 0});
        tbl.push_back('{mk(0, 0, nop),  0, 0, 0, 0, 0, 0});

        foreach (tbl[r]) begin
            apply(tbl[r].in);
            getact(0, st, kl, fa, fb, sc, fc);
            chk($sformatf("row%0d_stall", r), 0, st, tbl[r].st);
            chk($sformatf("row%0d_kill", r), 0, kl, tbl[r].kl);
            chk($sformatf("row%0d_fwd_a", r), 0, fa, tbl[r].fa);
            chk($sformatf("row%0d_fwd_b", r), 0, fb, tbl[r].fb);
            chk($sformatf("row%0d_stall_cnt", r), 0, sc, tbl[r].sc);
            chk($sformatf("row%0d_flush_cnt", r), 0, fc, tbl[r].fc);
            tick();
        end

        // no forwarding: ORR waits until ADD X5 reaches WB
        apply(mk(1, 0, nop)); tick();
        orr = ins(1, 5, 7, 1, 1, 6, 1, 0);
        apply(mk(0, 0, ins(1, 9, 10, 1, 1, 5, 1, 0)));
        chk("s4_stall0", 1, int'(st1), 0);
        tick();
        apply(mk(0, 0, orr));
        chk("s4_stall1", 1, int'(st1), 1);
        chk("s4_fwd_stall1", 0, int'(st0), 0);
        tick();
        apply(mk(0, 0, orr));
        chk("s4_stall2", 1, int'(st1), 1);
        chk("s4_fwd_a_exmem", 0, int'(fa0), 2);
        tick();
        apply(mk(0, 0, orr));
        chk("s4_stall3", 1, int'(st1), 0);
        tick();
        apply(mk(0, 0, nop));
        chk("s4_fwd_a", 1, int'(fa1), 0);
        chk("s4_stall_cnt", 1, int'(sc1), 2);
        tick();

        // counter saturation in the 3-bit configuration
        apply(mk(1, 0, nop)); tick();
        repeat (10) begin apply(mk(0, 1, nop)); tick(); end
        ldl = ins(1, 1, 0, 1, 0, 1, 1, 1);
        repeat (20) begin apply(mk(0, 0, ldl)); tick(); end
        apply(mk(0, 0, nop));
        chk("sat_flush_cnt", 2, int'(fc2), 7);
        chk("sat_stall_cnt", 2, int'(sc2), 7);
        chk("wide_flush_cnt", 0, int'(fc0), 10);
        chk("wide_stall_cnt", 0, int'(sc0), 10);
        tick();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ins_t x;
            bit rst = ($urandom_range(0, 63) == 0);
            bit br  = ($urandom_range(0, 7) == 0);
            x.v   = ($urandom_range(0, 3) != 0);
            x.rs1 = rreg();
            x.rs2 = rreg();
            x.u1  = ($urandom_range(0, 4) != 0);
            x.u2  = ($urandom_range(0, 2) != 0);
            x.rd  = rreg();
            x.rw  = ($urandom_range(0, 3) != 0);
            x.mr  = x.rw && ($urandom_range(0, 2) == 0);
            apply(mk(rst, br, x));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
